sdram_port_arbiter: RTL and testbench

//  Shares the single Avalon-MM SDRAM controller port between the DVI write FIFO (frame capture) and the LED

---
 rtl/sdram_port_arbiter_if.sv | 38 +++
 rtl/sdram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the arbiter, the DVI write FIFO / LED read requester and the SDRAM controller.
// The master modport is the arbiter's view; the slave modport is the surrounding logic's view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              frameStart;
    logic              wrReq;
    logic [DATA_W-1:0] wrData;
    logic              wrEnable;
    logic              rdReq;
    logic [ADDR_W-1:0] rdAddress;
    logic              rdAddressAck;
    logic [DATA_W-1:0] rdData;
    logic              rdDataValid;
    logic [ADDR_W-1:0] avAddress;
    logic              avRead_n;
    logic              avWrite_n;
    logic [DATA_W-1:0] avWriteData;
    logic [DATA_W-1:0] avReadData;
    logic              avReadDataValid;
    logic              avWaitRequest;
    logic [1:0]        grant;

    modport master (
        input  frameStart, wrReq, wrData, rdReq, rdAddress,
               avReadData, avReadDataValid, avWaitRequest,
        output wrEnable, rdAddressAck, rdData, rdDataValid,
               avAddress, avRead_n, avWrite_n, avWriteData, grant
    );

    modport slave (
        output frameStart, wrReq, wrData, rdReq, rdAddress,
               avReadData, avReadDataValid, avWaitRequest,
        input  wrEnable, rdAddressAck, rdData, rdDataValid,
               avAddress, avRead_n, avWrite_n, avWriteData, grant
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM port between the DVI write FIFO and the LED read requester in bounded bursts.
// Define SDRAM_ARB_READ_PRIORITY_EN to let reads win every IDLE decision; default is round-robin.
//  state | meaning
//  IDLE  | dead cycle, pick next requester
//  WRITE | pop FIFO words to SDRAM, up to BURST_SIZE beats
//  READ  | issue read commands, up to BURST_SIZE
//  DRAIN | no commands, wait for every issued read to return
module sdram_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int BURST_SIZE  = 8,
    parameter int FRAME_WORDS = 131072
) (
    input logic                  SDRAM_CLK,
    input logic                  reset,
    sdram_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BURST_SIZE) + 1;
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(BURST_SIZE);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t            state;
    logic              lastGrantRead;
    logic [ADDR_W-1:0] wrAddress;
    logic [CNT_W-1:0]  beatCnt;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  returned;
    logic [CNT_W-1:0]  returnedNext;
    logic              writeCmd;
    logic              readCmd;
    logic              writeBeat;
    logic              readAccept;
    logic              readReturn;

    // Commands are masked during reset so an aborted burst never pops or acks.
    always_comb begin
        writeCmd     = (state == WRITE) && bus.wrReq && !reset;
        readCmd      = (state == READ) && bus.rdReq && (issued < BURST_MAX) && !reset;
        writeBeat    = writeCmd && !bus.avWaitRequest;
        readAccept   = readCmd && !bus.avWaitRequest;
        readReturn   = bus.avReadDataValid && ((state == READ) || (state == DRAIN));
        returnedNext = (readReturn && (returned != BURST_MAX)) ? returned + CNT_W'(1) : returned;
    end

    assign bus.wrEnable     = writeBeat;
    assign bus.rdAddressAck = readAccept;
    assign bus.avWrite_n    = !writeCmd;
    assign bus.avRead_n     = !readCmd;
    assign bus.avAddress    = (state == READ) ? bus.rdAddress : wrAddress;
    assign bus.avWriteData  = bus.wrData;
    assign bus.grant        = state;

    always_ff @(posedge SDRAM_CLK) begin
        if (reset) begin
            state           <= IDLE;
            lastGrantRead   <= 1'b1;
            wrAddress       <= '0;
            beatCnt         <= '0;
            issued          <= '0;
            returned        <= '0;
            bus.rdData      <= '0;
            bus.rdDataValid <= 1'b0;
        end else begin
            bus.rdDataValid <= readReturn;
            if (readReturn)
                bus.rdData <= bus.avReadData;
            returned <= returnedNext;

            // A frame start wins over a same-cycle increment.
            if (bus.frameStart)
                wrAddress <= '0;
            else if (writeBeat)
                wrAddress <= (wrAddress == LAST_ADDR) ? '0 : wrAddress + ADDR_W'(1);

            case (state)
                IDLE: begin
                    beatCnt  <= '0;
                    issued   <= '0;
                    returned <= '0;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
                    if (bus.rdReq) begin
                        state         <= READ;
                        lastGrantRead <= 1'b1;
                    end else if (bus.wrReq) begin
                        state         <= WRITE;
                        lastGrantRead <= 1'b0;
                    end
`else
                    if (bus.wrReq && (!bus.rdReq || lastGrantRead)) begin
                        state         <= WRITE;
                        lastGrantRead <= 1'b0;
                    end else if (bus.rdReq) begin
                        state         <= READ;
                        lastGrantRead <= 1'b1;
                    end
`endif
                end
                WRITE: begin
                    if (writeBeat)
                        beatCnt <= beatCnt + CNT_W'(1);
                    if (!bus.wrReq || (writeBeat && (beatCnt == LAST_BEAT)))
                        state <= IDLE;
                end
                READ: begin
                    if (readAccept)
                        issued <= issued + CNT_W'(1);
                    if (!bus.rdReq || (readAccept && (issued == LAST_BEAT)))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (returnedNext == issued)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: write table with wrap/frame/stall rows, then read,
// reset-abort and contention sequences against a 3-cycle-latency controller model.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int BURST  = 8;
    localparam int FRAME  = 18;

    typedef struct {
        logic              fs;
        logic              wr;
        logic              wt;
        logic [DATA_W-1:0] data;
        logic [1:0]        grant;
        logic              wrEn;
        logic              wrN;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    logic SDRAM_CLK = 1'b0;
    logic reset     = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    vec_t vecs[$];

    // controller model / observation state
    logic [2:0]        vPipe;
    logic [DATA_W-1:0] dPipe [3];
    logic              accSeen  = 1'b0;
    logic              ackSeen  = 1'b0;
    logic [ADDR_W-1:0] addrSeen = '0;
    int                accCnt   = 0;
    int                valCnt   = 0;
    int                violations = 0;

    // main-sequence working variables
    logic [1:0] eGrant;
    logic       eAck;
    logic       eVal;
    logic [1:0] g;
    logic [1:0] prevG;
    logic [1:0] seen[$];
    logic [1:0] expSeq[4];
    int         firstPops;
    logic       firstAddrDone;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_SIZE(BURST), .FRAME_WORDS(FRAME)
    ) dut (
        .SDRAM_CLK(SDRAM_CLK),
        .reset(reset),
        .bus(bus)
    );

    always #5 SDRAM_CLK = ~SDRAM_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addV(input logic fs, input logic wr, input logic wt, input logic [1:0] gr,
                        input logic wrEn, input logic wrN, input int addr);
        vec_t v;
        v.fs    = fs;
        v.wr    = wr;
        v.wt    = wt;
        v.addr  = ADDR_W'(addr);
        v.data  = 16'hD000 | DATA_W'(addr);
        v.grant = gr;
        v.wrEn  = wrEn;
        v.wrN   = wrN;
        vecs.push_back(v);
    endtask

    always @(negedge SDRAM_CLK) begin
        accSeen  = !bus.avRead_n && !bus.avWaitRequest;
        ackSeen  = bus.rdAddressAck;
        addrSeen = bus.avAddress;
        if (!bus.avWrite_n && (accCnt > valCnt))
            violations++;
        if (accSeen)
            accCnt++;
        if (bus.avReadDataValid)
            valCnt++;
    end

    // SDRAM controller with fixed read latency of 3, plus the LED requester's address counter
    initial begin
        bus.avReadDataValid = 1'b0;
        bus.avReadData      = '0;
        bus.rdAddress       = 24'h000100;
        vPipe               = '0;
        for (int i = 0; i < 3; i++) dPipe[i] = '0;
        forever begin
            @(posedge SDRAM_CLK);
            #1;
            if (ackSeen)
                bus.rdAddress = bus.rdAddress + 24'd1;
            vPipe    = {vPipe[1:0], accSeen};
            dPipe[2] = dPipe[1];
            dPipe[1] = dPipe[0];
            dPipe[0] = accSeen ? (addrSeen[15:0] ^ 16'h5A5A) : 16'h0000;
            bus.avReadDataValid = vPipe[2];
            bus.avReadData      = dPipe[2];
        end
    end

    initial begin
        bus.frameStart    = 1'b0;
        bus.wrReq         = 1'b0;
        bus.wrData        = '0;
        bus.rdReq         = 1'b0;
        bus.avWaitRequest = 1'b0;

        // write-only bursts, wrap at FRAME, early exit, frame restart, stall
        addV(0, 1, 0, 2'd0, 0, 1, 0);
        for (int i = 0; i < 8; i++) addV(0, 1, 0, 2'd1, 1, 0, i);
        addV(0, 1, 0, 2'd0, 0, 1, 0);
        for (int i = 8; i < 16; i++) addV(0, 1, 0, 2'd1, 1, 0, i);
        addV(0, 1, 0, 2'd0, 0, 1, 0);
        addV(0, 1, 0, 2'd1, 1, 0, 16);
        addV(0, 1, 0, 2'd1, 1, 0, 17);
        addV(0, 1, 0, 2'd1, 1, 0, 0);
        addV(0, 1, 0, 2'd1, 1, 0, 1);
        addV(0, 0, 0, 2'd1, 0, 1, 0);
        addV(0, 0, 0, 2'd0, 0, 1, 0);
        addV(0, 1, 0, 2'd0, 0, 1, 0);
        addV(0, 1, 0, 2'd1, 1, 0, 2);
        addV(1, 1, 0, 2'd1, 1, 0, 3);
        addV(0, 1, 0, 2'd1, 1, 0, 0);
        addV(0, 1, 0, 2'd1, 1, 0, 1);
        for (int i = 0; i < 5; i++) addV(0, 1, 1, 2'd1, 0, 0, 2);
        addV(0, 1, 0, 2'd1, 1, 0, 2);
        addV(0, 1, 0, 2'd1, 1, 0, 3);
        addV(0, 1, 0, 2'd1, 1, 0, 4);
        addV(0, 1, 0, 2'd1, 1, 0, 5);
        addV(0, 0, 0, 2'd0, 0, 1, 0);

        repeat (3) @(posedge SDRAM_CLK);
        #1;
        reset = 1'b0;
        @(negedge SDRAM_CLK);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_avRead_n", 32'(bus.avRead_n), 32'd1);
        check("rst_avWrite_n", 32'(bus.avWrite_n), 32'd1);
        check("rst_wrEnable", 32'(bus.wrEnable), 32'd0);
        check("rst_rdAddressAck", 32'(bus.rdAddressAck), 32'd0);
        check("rst_rdDataValid", 32'(bus.rdDataValid), 32'd0);
        check("rst_rdData", 32'(bus.rdData), 32'd0);
        @(posedge SDRAM_CLK);
        #1;

        foreach (vecs[i]) begin
            bus.frameStart    = vecs[i].fs;
            bus.wrReq         = vecs[i].wr;
            bus.avWaitRequest = vecs[i].wt;
            bus.wrData        = vecs[i].data;
            @(negedge SDRAM_CLK);
            check($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(vecs[i].grant));
            check($sformatf("tbl%0d_wrEnable", i), 32'(bus.wrEnable), 32'(vecs[i].wrEn));
            check($sformatf("tbl%0d_avWrite_n", i), 32'(bus.avWrite_n), 32'(vecs[i].wrN));
            check($sformatf("tbl%0d_avRead_n", i), 32'(bus.avRead_n), 32'd1);
            if (!vecs[i].wrN) begin
                check($sformatf("tbl%0d_avAddress", i), 32'(bus.avAddress), 32'(vecs[i].addr));
                check($sformatf("tbl%0d_avWriteData", i), 32'(bus.avWriteData), 32'(vecs[i].data));
            end
            @(posedge SDRAM_CLK);
            #1;
        end
        bus.frameStart    = 1'b0;
        bus.wrReq         = 1'b0;
        bus.avWaitRequest = 1'b0;

        // read-only burst, drain, then an empty READ that drains on entry
        for (int k = 0; k < 16; k++) begin
            bus.rdReq = (k <= 12);
            @(negedge SDRAM_CLK);
            eGrant = (k == 0 || k == 12 || k == 15) ? 2'd0 : ((k <= 8 || k == 13) ? 2'd2 : 2'd3);
            eAck   = (k >= 1 && k <= 8);
            eVal   = (k >= 5 && k <= 12);
            check($sformatf("rd%0d_grant", k), 32'(bus.grant), 32'(eGrant));
            check($sformatf("rd%0d_ack", k), 32'(bus.rdAddressAck), 32'(eAck));
            check($sformatf("rd%0d_avRead_n", k), 32'(bus.avRead_n), 32'(!eAck));
            check($sformatf("rd%0d_rdDataValid", k), 32'(bus.rdDataValid), 32'(eVal));
            if (eAck)
                check($sformatf("rd%0d_avAddress", k), 32'(bus.avAddress), 32'h100 + 32'(k - 1));
            if (eVal)
                check($sformatf("rd%0d_rdData", k), 32'(bus.rdData),
                      32'(16'(32'h100 + 32'(k - 5)) ^ 16'h5A5A));
            @(posedge SDRAM_CLK);
            #1;
        end

        // reset with three reads in flight
        for (int q = 0; q < 8; q++) begin
            bus.rdReq = (q <= 4);
            reset     = (q == 4);
            @(negedge SDRAM_CLK);
            if (q == 0) check("rr0_grant", 32'(bus.grant), 32'd0);
            if (q >= 1 && q <= 3) begin
                check($sformatf("rr%0d_grant", q), 32'(bus.grant), 32'd2);
                check($sformatf("rr%0d_ack", q), 32'(bus.rdAddressAck), 32'd1);
            end
            if (q == 4) begin
                check("rr4_ack", 32'(bus.rdAddressAck), 32'd0);
                check("rr4_avRead_n", 32'(bus.avRead_n), 32'd1);
            end
            if (q >= 5) begin
                check($sformatf("rr%0d_grant", q), 32'(bus.grant), 32'd0);
                check($sformatf("rr%0d_rdDataValid", q), 32'(bus.rdDataValid), 32'd0);
                check($sformatf("rr%0d_avRead_n", q), 32'(bus.avRead_n), 32'd1);
                check($sformatf("rr%0d_rdData", q), 32'(bus.rdData), 32'd0);
            end
            @(posedge SDRAM_CLK);
            #1;
        end
        reset = 1'b0;

        // both requesters held
`ifdef SDRAM_ARB_READ_PRIORITY_EN
        expSeq = '{2'd2, 2'd2, 2'd2, 2'd2};
`else
        expSeq = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
        prevG         = 2'd0;
        firstPops     = 0;
        firstAddrDone = 1'b0;
        bus.wrReq     = 1'b1;
        bus.rdReq     = 1'b1;
        bus.wrData    = 16'hBEEF;
        for (int c = 0; c < 60; c++) begin
            @(negedge SDRAM_CLK);
            g = bus.grant;
            if ((g == 2'd1 || g == 2'd2) && g != prevG)
                seen.push_back(g);
            if (g == 2'd1 && seen.size() == 1) begin
                if (bus.wrEnable) firstPops++;
                if (!firstAddrDone) begin
                    check("alt_first_wr_addr", 32'(bus.avAddress), 32'd0);
                    firstAddrDone = 1'b1;
                end
            end
            prevG = g;
            @(posedge SDRAM_CLK);
            #1;
        end
        bus.wrReq = 1'b0;
        bus.rdReq = 1'b0;
        repeat (12) @(posedge SDRAM_CLK);
        #1;

        check("alt_burst_count_ge4", 32'(seen.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size())
                check($sformatf("alt_grant%0d", i), 32'(seen[i]), 32'(expSeq[i]));
        end
`ifndef SDRAM_ARB_READ_PRIORITY_EN
        check("alt_first_pops", 32'(firstPops), 32'd8);
`endif
        check("no_write_with_reads_in_flight", 32'(violations), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
